posit_to_float_4: RTL and testbench

- Pipelined converter from 32-bit posit (ES=2) to IEEE-754 binary32.
- It is the opposite direction of the posit multiplier's encode path. It decodes sign, regime, exponent and fraction, then rounds and packs a float.
- It sits at the accelerator output so posit results (e.g. PairHMM probabilities) can be handed to host software as floats.
- Handshake style matches the posit arithmetic units: start/done, 4-cycle latency, one conversion per cycle.

---
 rtl/posit_to_float_4.sv | 118 +++++++++++
 tb/tb_posit_to_float_4.sv | 125 ++++++++++++
 2 files changed

// File: rtl/posit_to_float_4.sv
// 4-stage posit<32,2> to IEEE-754 binary32 converter.
// r0 latches the operand, r1 decodes regime/exponent/fraction, r2 rounds (RNE), r3 packs.
module posit_to_float_4 #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] in,
  output logic [31:0]      result,
  output logic             nar,
  output logic             zero,
  output logic             done
);
  localparam int STAGES = 3;
  localparam int TW     = NBITS - 3;   // bits that can follow the first regime bit and its terminator
  localparam int XW     = TW - ES;     // 27 posit fraction bits at most

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              nar;
    logic signed [8:0] scale;
    logic [XW-1:0]     frac;
  } dec_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              nar;
    logic signed [8:0] scale;
    logic [FBITS-1:0]  frac;
  } rnd_t;

  logic [STAGES:0]   vld_pipe;
  logic [NBITS-1:0]  in_q;
  dec_t              dec_d, dec_q;
  rnd_t              rnd_d, rnd_q;

  // r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      in_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], start};
      in_q     <= in;
    end
  end

  // r1 decode
  logic [NBITS-2:0]  body, run_x;
  logic [5:0]        run;
  logic signed [6:0] k;
  logic [TW-1:0]     tail;

  always_comb begin
    body  = in_q[NBITS-1] ? ((NBITS-1)'(0) - in_q[NBITS-2:0]) : in_q[NBITS-2:0];
    run_x = body[NBITS-2] ? ~body : body;
    // run = leading count of bits equal to body[30]; 31 when the regime fills the word
    run   = 6'd31;
    for (int i = 0; i < NBITS-1; i++)
      if (run_x[i]) run = 6'(NBITS-2-i);
    k     = body[NBITS-2] ? ($signed({1'b0, run}) - 7'sd1) : -$signed({1'b0, run});
    tail  = body[TW-1:0] << (run - 6'd1);
    dec_d.sign  = in_q[NBITS-1];
    dec_d.zero  = (in_q == '0);
    dec_d.nar   = (in_q == {1'b1, {(NBITS-1){1'b0}}});
    dec_d.scale = {k, tail[TW-1 -: ES]};   // 4k + e
    dec_d.frac  = tail[XW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  // r2 round to nearest even, 27 -> 23 fraction bits
  logic            inc;
  logic [FBITS:0]  fsum;

  always_comb begin
    inc  = dec_q.frac[3] & (dec_q.frac[4] | (|dec_q.frac[2:0]));
    fsum = {1'b0, dec_q.frac[XW-1:4]} + {{FBITS{1'b0}}, inc};
    rnd_d.sign  = dec_q.sign;
    rnd_d.zero  = dec_q.zero;
    rnd_d.nar   = dec_q.nar;
    rnd_d.scale = fsum[FBITS] ? dec_q.scale + 9'sd1 : dec_q.scale;
    rnd_d.frac  = fsum[FBITS] ? '0 : fsum[FBITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_q <= '0;
    else        rnd_q <= rnd_d;
  end

  // r3 pack; outputs hold between valid results
  logic [8:0] bexp;
  assign bexp = rnd_q.scale + 9'sd127;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      nar    <= 1'b0;
      zero   <= 1'b0;
    end else if (vld_pipe[STAGES-1]) begin
      nar  <= rnd_q.nar;
      zero <= rnd_q.zero;
      if (rnd_q.nar)       result <= 32'h7FC0_0000;
      else if (rnd_q.zero) result <= 32'h0000_0000;
      else                 result <= {rnd_q.sign, bexp[7:0], rnd_q.frac};
    end
  end

  assign done = vld_pipe[STAGES];
endmodule

// File: tb/tb_posit_to_float_4.sv
// Directed bench for posit_to_float_4: reset, values, extremes, rounding, specials, streaming.
module tb_posit_to_float_4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] result;
  logic        nar, zero, done;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] ops [8] = '{32'h40000000, 32'hC0000000, 32'h48000000, 32'h7FFFFFFF,
                           32'h00000001, 32'h80000001, 32'h40000018, 32'h40000009};
  logic [31:0] exps[8] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'h7B800000,
                           32'h03800000, 32'hFB800000, 32'h3F800002, 32'h3F800001};

  posit_to_float_4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(din),
    .result(result), .nar(nar), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One isolated conversion; samples on negedges, done expected on the 4th.
  task automatic conv(input string tag, input logic [31:0] p, input logic [31:0] f,
                      input logic z, input logic n);
    @(negedge clk); din = p; start = 1'b1;
    @(negedge clk); start = 1'b0; din = 32'hDEADBEEF;
    chk({tag, "_early0"}, 32'(done), 32'd0);
    @(negedge clk); chk({tag, "_early1"}, 32'(done), 32'd0);
    @(negedge clk); chk({tag, "_early2"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_res"}, result, f);
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_nar"}, 32'(nar), 32'(n));
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, result, f);
  endtask

  initial begin
    // reset with start streaming
    start = 1'b1; din = 32'h40000000;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {30'd0, nar, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst0", 32'(done), 32'd0);
    @(negedge clk); chk("post_rst1", 32'(done), 32'd0);
    @(negedge clk); chk("post_rst2", 32'(done), 32'd0);
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_res", result, 32'h3F800000);
    start = 1'b0;
    repeat (5) @(negedge clk);

    conv("one",      32'h40000000, 32'h3F800000, 1'b0, 1'b0);
    conv("mone",     32'hC0000000, 32'hBF800000, 1'b0, 1'b0);
    conv("two",      32'h48000000, 32'h40000000, 1'b0, 1'b0);
    conv("mtwo",     32'hB8000000, 32'hC0000000, 1'b0, 1'b0);
    conv("sixteenth",32'h20000000, 32'h3D800000, 1'b0, 1'b0);
    conv("maxpos",   32'h7FFFFFFF, 32'h7B800000, 1'b0, 1'b0);
    conv("minpos",   32'h00000001, 32'h03800000, 1'b0, 1'b0);
    conv("negmax",   32'h80000001, 32'hFB800000, 1'b0, 1'b0);
    conv("tie_even", 32'h40000008, 32'h3F800000, 1'b0, 1'b0);
    conv("tie_odd",  32'h40000018, 32'h3F800002, 1'b0, 1'b0);
    conv("above",    32'h40000009, 32'h3F800001, 1'b0, 1'b0);
    conv("carry",    32'h47FFFFFF, 32'h40000000, 1'b0, 1'b0);
    conv("zero",     32'h00000000, 32'h00000000, 1'b1, 1'b0);
    conv("nar",      32'h80000000, 32'h7FC00000, 1'b0, 1'b1);

    // 8-deep back-to-back burst
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i >= 4 && i < 12) begin
        chk($sformatf("burst_done%0d", i-4), 32'(done), 32'd1);
        chk($sformatf("burst_res%0d", i-4), result, exps[i-4]);
      end else if (i >= 1) begin
        chk($sformatf("burst_idle%0d", i), 32'(done), 32'd0);
      end
      if (i < 8) begin start = 1'b1; din = ops[i]; end
      else start = 1'b0;
    end
    repeat (3) @(negedge clk);

    // reset pulse at cycle 2 of a burst: ops 0..2 are lost, op 3 is the first to complete
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 2) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_res", result, 32'h0);
      end
      if (i == 3) rst_n = 1'b1;
      if (i >= 3 && i < 7) chk($sformatf("flush_idle%0d", i), 32'(done), 32'd0);
      if (i >= 7 && i < 12) begin
        chk($sformatf("flush_done%0d", i-4), 32'(done), 32'd1);
        chk($sformatf("flush_res%0d", i-4), result, exps[i-4]);
      end
      if (i == 12) chk("flush_tail", 32'(done), 32'd0);
      if (i < 8) begin start = 1'b1; din = ops[i]; end
      else start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
